// File: rtl/crt_recombine.sv
// CRT recombination: m = mq + q * (((mp - mq) * qinv) mod p), computed with a
// bit-serial modular multiply followed by a bit-serial shift-add product.
module crt_recombine #(
    parameter int N = 512
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [N-1:0]     mp,
    input  logic [N-1:0]     mq,
    input  logic [N-1:0]     p,
    input  logic [N-1:0]     q,
    input  logic [N-1:0]     qinv,
    output logic [2*N-1:0]   result,
    output logic             done
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    typedef enum logic [2:0] {
        IDLE,
        SUB,
        MODMUL,
        MUL,
        ADD
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     mp_q, mp_d;
    logic [N-1:0]     mq_q, mq_d;
    logic [N-1:0]     p_q, p_d;
    logic [N-1:0]     q_q, q_d;
    logic [N-1:0]     qinv_q, qinv_d;
    logic [N-1:0]     d_q, d_d;
    logic [N+1:0]     acc_q, acc_d;
    logic [N-1:0]     h_q, h_d;
    logic [2*N-1:0]   prod_q, prod_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2*N-1:0]   result_q, result_d;
    logic             done_q, done_d;

    logic [N+1:0]     p_ext;
    logic [N+1:0]     mm_sum;
    logic [N+1:0]     mm_sub1;
    logic [N+1:0]     mm_sub2;

    // acc < p and qinv < p keep 2*acc + qinv below 3p, so two conditional
    // subtractions always bring the sum back under p.
    always_comb begin
        p_ext   = {2'b00, p_q};
        mm_sum  = {acc_q[N:0], 1'b0} + (d_q[N-1] ? {2'b00, qinv_q} : '0);
        mm_sub1 = (mm_sum >= p_ext) ? (mm_sum - p_ext) : mm_sum;
        mm_sub2 = (mm_sub1 >= p_ext) ? (mm_sub1 - p_ext) : mm_sub1;
    end

    // NOTE: every _d signal takes its _q value first, so no path through this
    // block can leave a signal unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        mp_d     = mp_q;
        mq_d     = mq_q;
        p_d      = p_q;
        q_d      = q_q;
        qinv_d   = qinv_q;
        d_d      = d_q;
        acc_d    = acc_q;
        h_d      = h_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mp_d    = mp;
                    mq_d    = mq;
                    p_d     = p;
                    q_d     = q;
                    qinv_d  = qinv;
                    state_d = SUB;
                end
            end
            SUB: begin
                // Modular wrap-around makes mp - mq + p exact when mp < mq.
                d_d     = (mp_q >= mq_q) ? (mp_q - mq_q) : (mp_q - mq_q + p_q);
                acc_d   = '0;
                cnt_d   = CNT_LAST;
                state_d = MODMUL;
            end
            MODMUL: begin
                acc_d = mm_sub2;
                d_d   = {d_q[N-2:0], 1'b0};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    h_d     = mm_sub2[N-1:0];
                    prod_d  = '0;
                    cnt_d   = CNT_LAST;
                    state_d = MUL;
                end
            end
            MUL: begin
                prod_d = {prod_q[2*N-2:0], 1'b0} + (h_q[N-1] ? {{N{1'b0}}, q_q} : '0);
                h_d    = {h_q[N-2:0], 1'b0};
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = ADD;
                end
            end
            ADD: begin
                result_d = prod_q + {{N{1'b0}}, mq_q};
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: reset clears every register, including the operand copies, so an
    // aborted operation leaves nothing behind.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            mp_q     <= '0;
            mq_q     <= '0;
            p_q      <= '0;
            q_q      <= '0;
            qinv_q   <= '0;
            d_q      <= '0;
            acc_q    <= '0;
            h_q      <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mp_q     <= mp_d;
            mq_q     <= mq_d;
            p_q      <= p_d;
            q_q      <= q_d;
            qinv_q   <= qinv_d;
            d_q      <= d_d;
            acc_q    <= acc_d;
            h_q      <= h_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign result = result_q;
    assign done   = done_q;

endmodule

// File: tb/tb_crt_recombine.sv
// Directed bench for crt_recombine: a scoreboard queue holds expected results
// and completion cycles; a negedge monitor pops and compares on each done.
module tb_crt_recombine;

    localparam int N   = 512;
    localparam int W2  = 2 * N;
    localparam int LAT = 2 * N + 2;

    logic            clk = 1'b0;
    logic            resetn;
    logic            start;
    logic [N-1:0]    mp, mq, p, q, qinv;
    logic [W2-1:0]   result;
    logic            done;

    typedef struct {
        logic [W2-1:0] res;
        int unsigned   cyc;
        string         tag;
    } exp_t;

    exp_t        sb[$];
    exp_t        e_mon;
    int          total = 0;
    int          bad   = 0;
    int unsigned cyc   = 0;
    logic        prev_done = 1'b0;

    always #5 clk = ~clk;

    crt_recombine #(.N(N)) dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .mp     (mp),
        .mq     (mq),
        .p      (p),
        .q      (q),
        .qinv   (qinv),
        .result (result),
        .done   (done)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [W2-1:0] obs, input logic [W2-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h (low 256 bits)", tag, obs[255:0], exp[255:0]);
        end
    endtask

    always @(negedge clk) begin
        if (prev_done === 1'b1) check("done_width", W2'(done), '0);
        if (done === 1'b1) begin
            total++;
            assert (sb.size() != 0) else begin
                bad++;
                $error("FAIL spurious_done: observed done=1 at cycle %0d expected no completion", cyc);
            end
            if (sb.size() != 0) begin
                e_mon = sb.pop_front();
                check({e_mon.tag, "_result"}, result, e_mon.res);
                check({e_mon.tag, "_latency"}, W2'(cyc), W2'(e_mon.cyc));
            end
        end
        prev_done <= done;
    end

    function automatic logic [N-1:0] rnd_wide();
        logic [N-1:0] v;
        for (int i = 0; i < N / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [W2-1:0] crt_model(input logic [N-1:0] a_mp, a_mq, a_p, a_q, a_qinv);
        logic [W2-1:0] d, h;
        if (a_mp >= a_mq) d = W2'(a_mp) - W2'(a_mq);
        else              d = W2'(a_mp) + W2'(a_p) - W2'(a_mq);
        h = (d * W2'(a_qinv)) % W2'(a_p);
        return W2'(a_q) * h + W2'(a_mq);
    endfunction

    function automatic logic [W2-1:0] modexp(input logic [W2-1:0] b, input logic [127:0] ex,
                                             input logic [W2-1:0] m);
        logic [W2-1:0] r, bb;
        r  = 1;
        bb = b % m;
        for (int i = 127; i >= 0; i--) begin
            r = (r * r) % m;
            if (ex[i]) r = (r * bb) % m;
        end
        return r;
    endfunction

    task automatic launch(input logic [N-1:0] a_mp, a_mq, a_p, a_q, a_qinv,
                          input logic [W2-1:0] exp_res, input string tag);
        exp_t e;
        @(negedge clk);
        mp = a_mp; mq = a_mq; p = a_p; q = a_q; qinv = a_qinv;
        start = 1'b1;
        e.res = exp_res;
        e.cyc = cyc + 1 + LAT;
        e.tag = tag;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        // Operands must be captured at the start edge; scramble them now.
        mp = rnd_wide(); mq = rnd_wide(); p = rnd_wide(); q = rnd_wide(); qinv = rnd_wide();
    endtask

    task automatic drain(input int budget, input string tag);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("FAIL %s_timeout: observed %0d pending completions expected 0", tag, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        logic [W2-1:0] mp_w, mq_w, m_w, pq_w, qi_w;
        logic [N-1:0]  pr[4];
        logic [N-1:0]  tp, tq, tmp, tmq, tqi;
        int unsigned   base;

        resetn = 1'b0;
        start  = 1'b0;
        mp = '0; mq = '0; p = '0; q = '0; qinv = '0;
        repeat (3) @(negedge clk);
        check("reset_result", result, '0);
        check("reset_done", W2'(done), '0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Small operands, including the borrow path and the extremes.
        launch(N'(6),  N'(1), N'(11), N'(7), N'(8), W2'(50), "basic");
        drain(LAT + 20, "basic");
        launch(N'(2),  N'(6), N'(11), N'(7), N'(8), W2'(13), "borrow");
        drain(LAT + 20, "borrow");
        launch(N'(10), N'(6), N'(11), N'(7), N'(8), W2'(76), "maxval");
        drain(LAT + 20, "maxval");
        launch(N'(0),  N'(0), N'(11), N'(7), N'(8), W2'(0),  "zero");
        drain(LAT + 20, "zero");

        // A start raised mid-operation must be ignored entirely.
        launch(N'(6), N'(1), N'(11), N'(7), N'(8), W2'(50), "ignore");
        repeat (299) @(negedge clk);
        mp = N'(2); mq = N'(6); p = N'(11); q = N'(7); qinv = N'(8);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain(LAT + 20, "ignore");
        repeat (LAT + 10) @(negedge clk);

        // Reset mid-operation aborts without a completion.
        launch(N'(10), N'(6), N'(11), N'(7), N'(8), W2'(76), "abort");
        repeat (599) @(negedge clk);
        resetn = 1'b0;
        #1;
        check("abort_result", result, '0);
        check("abort_done", W2'(done), '0);
        sb.delete();
        @(negedge clk);
        resetn = 1'b1;
        repeat (LAT + 20) @(negedge clk);
        launch(N'(6), N'(1), N'(11), N'(7), N'(8), W2'(50), "post_reset");
        drain(LAT + 20, "post_reset");

        // Start held high: back-to-back operations every LAT+1 cycles.
        @(negedge clk);
        mp = N'(2); mq = N'(6); p = N'(11); q = N'(7); qinv = N'(8);
        start = 1'b1;
        base = cyc + 1;
        for (int k = 0; k < 3; k++) begin
            exp_t e;
            e.res = W2'(13);
            e.cyc = base + LAT + k * (LAT + 1);
            e.tag = $sformatf("held%0d", k);
            sb.push_back(e);
        end
        drain(4 * (LAT + 1), "held");
        start = 1'b0;
        repeat (LAT + 10) @(negedge clk);

        // Mersenne prime pairs: recombination must reproduce a random m < p*q.
        pr[0] = N'(1) << 31; pr[0] = pr[0] - 1;
        pr[1] = N'(1) << 61; pr[1] = pr[1] - 1;
        pr[2] = N'(1) << 89; pr[2] = pr[2] - 1;
        pr[3] = N'(1) << 127; pr[3] = pr[3] - 1;
        for (int k = 0; k < 4; k++) begin
            tp   = (k == 0) ? pr[1] : (k == 1) ? pr[2] : pr[3];
            tq   = (k == 0) ? pr[0] : (k == 1) ? pr[1] : (k == 2) ? pr[1] : pr[2];
            pq_w = W2'(tp) * W2'(tq);
            m_w  = {W2'(rnd_wide()) << N | W2'(rnd_wide())} % pq_w;
            mp_w = m_w % W2'(tp);
            mq_w = m_w % W2'(tq);
            qi_w = modexp(W2'(tq), 128'(tp) - 128'd2, W2'(tp));
            launch(mp_w[N-1:0], mq_w[N-1:0], tp, tq, qi_w[N-1:0], m_w, $sformatf("prime%0d", k));
            drain(LAT + 20, $sformatf("prime%0d", k));
        end

        // Full-width random operands against the reference formula.
        for (int k = 0; k < 4; k++) begin
            tp  = rnd_wide();
            tp[N-1] = 1'b1;
            tp[0]   = 1'b1;
            tq  = rnd_wide();
            tq[N-1] = 1'b0;
            tq[0]   = 1'b1;
            tmp = rnd_wide() % tp;
            tmq = rnd_wide() % tq;
            tqi = rnd_wide() % tp;
            launch(tmp, tmq, tp, tq, tqi, crt_model(tmp, tmq, tp, tq, tqi), $sformatf("wide%0d", k));
            drain(LAT + 20, $sformatf("wide%0d", k));
        end

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/crt_recombine.md
CRT_RECOMBINE -- requirements
Module: crt_recombine

Interface
REQ-001 The block SHALL have one parameter: N, default 512, width in bits of each CRT half (p, q, mp, mq, qinv).
REQ-002 The block SHALL use one clock, clk, with an asynchronous, active-low reset, resetn; all state SHALL be clocked on the rising edge of clk.
REQ-003 Port list (name, direction, width, meaning) SHALL be:
- clk: input, 1, clock.
- resetn: input, 1, asynchronous active-low reset.
- start: input, 1, request; sampled only in IDLE.
- mp: input, N, half-result mod p (mp < p).
- mq: input, N, half-result mod q (mq < q).
- p: input, N, prime modulus; p > q.
- q: input, N, prime modulus.
- qinv: input, N, q^-1 mod p (qinv < p).
- result: output, 2N, recombined value m = mq + q*(((mp-mq)*qinv) mod p).
- done: output, 1, one-cycle completion pulse.

Function
REQ-004 The block SHALL be the consumer of the CRT exponentiation output; it turns the pair {mp, mq} into the full 2N-bit plaintext.
REQ-005 The FSM SHALL have states IDLE, SUB, MODMUL, MUL and ADD.
REQ-006 In IDLE, start=1 SHALL register mp, mq, p, q and qinv into internal registers and enter SUB on that edge (E0); input changes after E0 SHALL NOT affect the operation.
REQ-007 At E0+1, SUB SHALL compute d = mp-mq if mp>=mq, else mp-mq+p (N-bit result, borrow handled), and SHALL enter MODMUL with the bit counter at N-1.
REQ-008 MODMUL SHALL perform N MSB-first interleaved iterations over the bits of d: acc = 2*acc + d[i]*qinv, followed by conditional subtraction(s) of p so that acc < p after every iteration.
REQ-009 The MODMUL intermediate SHALL be N+2 bits wide; up to two subtractions of p SHALL be applied per iteration.
REQ-010 On the iteration with counter = 0, MODMUL SHALL store h = acc and enter MUL at edge E0+N+1.
REQ-011 MUL SHALL compute prod = q*h as a 2N-bit shift-add product over N iterations, one bit of h per cycle, with no overflow beyond 2N bits; it SHALL enter ADD at edge E0+2N+1.
REQ-012 ADD SHALL, at edge E0+2N+2, set result = prod + mq (2N bits, no overflow since the result < p*q), set done=1 and return to IDLE.
REQ-013 Total latency SHALL be fixed at 2N+2 edges from the start-sampling edge to done=1 (1026 for N=512), independent of operand values.
REQ-014 done SHALL be high for exactly one cycle; it SHALL be cleared on the next edge.
REQ-015 result SHALL hold its value from the done edge until the next completion or reset.
REQ-016 start SHALL be ignored in every non-IDLE state (no queuing, no restart).
REQ-017 A start held high through completion SHALL begin a new operation at the edge after done, i.e. the first edge in IDLE.
REQ-018 Out-of-contract inputs (mp>=p, mq>=q, p<=q, wrong qinv) SHALL give an unspecified result, but SHALL still give done at the fixed latency.

Reset
REQ-019 While resetn=0, the block SHALL hold state=IDLE, result=0, done=0, and clear all internal registers and counters.
REQ-020 Reset asserted mid-operation SHALL abort immediately; after release the block SHALL wait in IDLE for a new start and SHALL NOT produce done for the aborted operation.

Verification
REQ-021 p=11, q=7, qinv=8, mp=6, mq=1 (zero-extended to N) -> done exactly 1026 edges after start, result=50.
REQ-022 Borrow path: p=11, q=7, qinv=8, mp=2, mq=6 -> result=13; max value mp=10, mq=6 -> result=76; zero mp=0, mq=0 -> result=0.
REQ-023 Full-width: 200 random 512-bit prime pairs with p>q and random m<pq -> result equals m per the reference model, latency 1026 on every run.
REQ-024 start pulsed again at E0+300 with different operands -> ignored; first result unchanged; single done at E0+1026.
REQ-025 resetn pulsed low at E0+600 -> result=0, done=0, no done afterwards; a new start after release completes correctly.
REQ-026 start held high continuously -> done pulses every 1027 cycles, one cycle wide each time.
